sram_2rw_param: RTL

Parametrised, synthesizable dual-port (2RW) SRAM macro model for the backend flow, generalising the fixed 64x128 2RW model to configurable width, depth and per-byte write masking. Both ports share one clock, have registered read data with a valid strobe, and have defined write-write and read-write collision resolution. A saturating counter and a sticky flag report collisions to the surrounding cache/register-file logic.

---
 rtl/sram_2rw_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sram_2rw_param.sv
// sram_2rw_param: parametrised dual-port (2RW) SRAM model with one shared clock.
// Each port can read or write in a cycle, and writes use per-byte masks.
// Read data is registered and comes with a one-cycle valid strobe.
// Same-address collisions are resolved as follows:
//   - Write-write: port 0 wins on any byte both ports write.
//   - Read-write: the read returns the old contents by default.
// Collisions set a sticky flag. Write-write collisions also step a saturating counter.
// Optional macro SRAM_BYPASS_EN: a same-address read-during-write on the opposite port
// returns the merged new data instead of the old contents.
module sram_2rw_param #(
  parameter int  DATA_WIDTH  = 64,
  parameter int  ADDR_WIDTH  = 7,
  parameter int  CNT_WIDTH   = 8,
  localparam int WMASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic                   csb1,
  input  logic                   web1,
  input  logic [WMASK_WIDTH-1:0] wmask1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0]  din1,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dvalid0,
  output logic                   dvalid1,
  output logic                   coll_flag,
  output logic [CNT_WIDTH-1:0]   coll_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   wr0, wr1, rd0, rd1;
  logic                   same_addr, ww_coll, rw_coll;
  logic [WMASK_WIDTH-1:0] wmask1_eff;
  logic [DATA_WIDTH-1:0]  rdata0, rdata1;

  logic [DATA_WIDTH-1:0]  dout0_d, dout0_q, dout1_d, dout1_q;
  logic                   dvalid0_d, dvalid0_q, dvalid1_d, dvalid1_q;
  logic                   coll_flag_d, coll_flag_q;
  logic [CNT_WIDTH-1:0]   coll_cnt_d, coll_cnt_q;

  // Replace the bytes of old_word selected by mask with the bytes of new_word
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]  old_word,
    input logic [DATA_WIDTH-1:0]  new_word,
    input logic [WMASK_WIDTH-1:0] mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Decode per-port operations and same-address collisions; an all-zero mask is not a write
  always_comb begin
    wr0        = ~csb0 & ~web0 & (|wmask0);
    wr1        = ~csb1 & ~web1 & (|wmask1);
    rd0        = ~csb0 & web0;
    rd1        = ~csb1 & web1;
    same_addr  = (addr0 == addr1);
    ww_coll    = wr0 & wr1 & same_addr;
    rw_coll    = same_addr & ((wr0 & rd1) | (wr1 & rd0));
    // Port 0 owns every byte it writes when both ports hit the same word
    wmask1_eff = ww_coll ? (wmask1 & ~wmask0) : wmask1;
  end

  // Read data source: old array contents, optionally merged with the opposite port's write
  always_comb begin
    rdata0 = mem_q[addr0];
    rdata1 = mem_q[addr1];
`ifdef SRAM_BYPASS_EN
    if (rd0 && wr1 && same_addr) rdata0 = merge_bytes(rdata0, din1, wmask1);
    if (rd1 && wr0 && same_addr) rdata1 = merge_bytes(rdata1, din0, wmask0);
`endif
  end

  // Next-state for read registers, valid strobes and collision reporting
  always_comb begin
    dout0_d     = rd0 ? rdata0 : dout0_q;
    dout1_d     = rd1 ? rdata1 : dout1_q;
    dvalid0_d   = rd0;
    dvalid1_d   = rd1;
    coll_flag_d = coll_flag_q | ww_coll | rw_coll;
    coll_cnt_d  = coll_cnt_q;
    if (ww_coll && (coll_cnt_q != {CNT_WIDTH{1'b1}})) begin
      coll_cnt_d = coll_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Array update; contents survive reset, reset only blocks writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wr1 && wmask1_eff[i]) mem_q[addr1][8*i +: 8] <= din1[8*i +: 8];
        if (wr0 && wmask0[i])     mem_q[addr0][8*i +: 8] <= din0[8*i +: 8];
      end
    end
  end

  // Output and status registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout0_q     <= '0;
      dout1_q     <= '0;
      dvalid0_q   <= 1'b0;
      dvalid1_q   <= 1'b0;
      coll_flag_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      dvalid0_q   <= dvalid0_d;
      dvalid1_q   <= dvalid1_d;
      coll_flag_q <= coll_flag_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign dout0     = dout0_q;
  assign dout1     = dout1_q;
  assign dvalid0   = dvalid0_q;
  assign dvalid1   = dvalid1_q;
  assign coll_flag = coll_flag_q;
  assign coll_cnt  = coll_cnt_q;

endmodule
